// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
// Accepts NUM_TAPS coefficients from an upstream valid/ready stream and
// replays each one, one cycle later, as a write strobe (coeff_update,
// coeff_sel, new_coeff) into a filter's coefficient bank.
// A load is started with start. It ends with a one-cycle done pulse, or
// with abort, or with a sticky error after TIMEOUT idle input cycles.
// Optional feature: define COEFF_CHECKSUM_EN to add a checksum[15:0] output.
// That output holds the modulo-2^16 sum of the coefficients accepted in the
// current load.
// dbg_state exposes the FSM state encoding
// (0 = IDLE, 1 = LOAD, 2 = DONE, 3 = ERR).
module fir_coeff_loader #(
    parameter int NUM_TAPS = 41,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [15:0] in_coeff,
    output logic        in_ready,
    output logic        coeff_update,
    output logic [5:0]  coeff_sel,
    output logic [15:0] new_coeff,
    output logic        busy,
    output logic        done,
    output logic        error,
`ifdef COEFF_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic [1:0]  dbg_state
);

    // Timer wide enough to hold TIMEOUT.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [5:0]    LAST_IDX     = 6'(NUM_TAPS - 1);
    localparam logic [TW-1:0] TIMER_EXPIRE = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    index_q, index_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          coeff_update_q, coeff_update_d;
    logic [5:0]    coeff_sel_q, coeff_sel_d;
    logic [15:0]   new_coeff_q, new_coeff_d;
    logic          handshake;

    // Handshake: in_valid and in_ready are both high on a rising edge.
    // in_ready depends only on state, never on in_valid.
    // Upstream holds in_coeff stable while in_valid is high and not yet
    // accepted.
    assign handshake = (state_q == S_LOAD) && in_valid;

    // Next-state, tap index, idle timer and write-strobe computation.
    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        timer_d        = timer_q;
        coeff_update_d = 1'b0;
        coeff_sel_d    = coeff_sel_q;
        new_coeff_d    = new_coeff_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    index_d = '0;
                    timer_d = '0;
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    coeff_update_d = 1'b1;
                    coeff_sel_d    = index_q;
                    new_coeff_d    = in_coeff;
                    timer_d        = '0;
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 6'd1;
                    end
                end else if (timer_q == TIMER_EXPIRE) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                // An abort wins over completion and timeout.
                // A write for a handshake taken in this same cycle still
                // goes out.
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    index_d = '0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            index_q        <= '0;
            timer_q        <= '0;
            coeff_update_q <= 1'b0;
            coeff_sel_q    <= '0;
            new_coeff_q    <= '0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            timer_q        <= timer_d;
            coeff_update_q <= coeff_update_d;
            coeff_sel_q    <= coeff_sel_d;
            new_coeff_q    <= new_coeff_d;
        end
    end

`ifdef COEFF_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // Running sum of accepted coefficients, restarted by every load start.
    always_comb begin
        checksum_d = checksum_q;
        if (((state_q == S_IDLE) || (state_q == S_ERR)) && start) begin
            checksum_d = '0;
        end else if (handshake) begin
            checksum_d = checksum_q + in_coeff;
        end
    end

    // Checksum register; it moves in the same cycle as coeff_update.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign coeff_update = coeff_update_q;
    assign coeff_sel    = coeff_sel_q;
    assign new_coeff    = new_coeff_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Testbench for fir_coeff_loader.
// The reference model follows the load rules directly:
// a loading flag, an accepted-tap count, an idle-cycle count and a running sum.
// Expected writes go through a queue and are popped as the DUT writes them.
module tb_fir_coeff_loader;

  localparam int NUM_TAPS = 41;
  localparam int TIMEOUT  = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [15:0] in_coeff;
  logic        in_ready;
  logic        coeff_update;
  logic [5:0]  coeff_sel;
  logic [15:0] new_coeff;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  dbg_state;
`ifdef COEFF_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  fir_coeff_loader #(.NUM_TAPS(NUM_TAPS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_coeff     (in_coeff),
    .in_ready     (in_ready),
    .coeff_update (coeff_update),
    .coeff_sel    (coeff_sel),
    .new_coeff    (new_coeff),
    .busy         (busy),
    .done         (done),
    .error        (error),
`ifdef COEFF_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .dbg_state    (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  bit          m_loading = 1'b0;
  bit          m_err     = 1'b0;
  bit          m_done    = 1'b0;
  bit          m_wr      = 1'b0;
  int          m_count   = 0;
  int          m_idle    = 0;
  logic [15:0] m_sum     = '0;

  // scoreboard: {sel, coeff}
  logic [21:0] exp_q[$];
  int          wr_seen   = 0;
  int          done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst, input bit st, input bit ab, input bit vld,
                      input logic [15:0] cf);
    logic [21:0] e;
    reset = rst; start = st; abort = ab; in_valid = vld; in_coeff = cf;
    if (rst) begin
      m_loading = 0; m_err = 0; m_done = 0; m_wr = 0;
      m_count = 0; m_idle = 0; m_sum = '0;
      exp_q.delete();
    end else begin
      m_wr = 0;
      if (m_loading) begin
        bit done_n = 0;
        if (vld) begin
          m_wr = 1;
          exp_q.push_back({6'(m_count), cf});
          m_sum = m_sum + cf;
          m_count++;
          m_idle = 0;
          if (m_count == NUM_TAPS) begin
            m_loading = 0;
            done_n = 1;
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_loading = 0;
            m_err = 1;
          end
        end
        if (ab) begin
          m_loading = 0;
          m_err = 0;
          done_n = 0;
        end
        m_done = done_n;
      end else if (m_done) begin
        m_done = 0;
      end else if (st) begin
        m_loading = 1; m_err = 0; m_count = 0; m_idle = 0; m_sum = '0;
      end
    end
    @(posedge clk);
    #1;
    check("coeff_update", 32'(coeff_update), 32'(m_wr));
    check("in_ready", 32'(in_ready), 32'(m_loading));
    check("busy", 32'(busy), 32'(m_loading));
    check("done", 32'(done), 32'(m_done));
    check("error", 32'(error), 32'(m_err));
`ifdef COEFF_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(m_sum));
`endif
    if (rst) begin
      check("reset_sel", 32'(coeff_sel), 32'd0);
      check("reset_coeff", 32'(new_coeff), 32'd0);
    end
    if (coeff_update === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_sel", 32'(coeff_sel), 32'(e[21:16]));
        check("write_coeff", 32'(new_coeff), 32'(e[15:0]));
      end
    end
    if (done === 1'b1) done_seen++;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 16'($urandom_range(0, 65535)));
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; in_valid = 0; in_coeff = '0;

    // reset with random input noise
    step(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 16'($urandom));
    step(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 16'($urandom));
    idle_step();

    // full load, in_valid held high, start held high (ignored while loading)
    wr_seen = 0; done_seen = 0;
    step(0, 1, 0, 0, 16'h0);
    for (int k = 0; k < NUM_TAPS; k++) step(0, 1, 0, 1, 16'(k + 1));
    idle_step();
    idle_step();
    check("full_load_writes", 32'(wr_seen), 32'(NUM_TAPS));
    check("full_load_done_count", 32'(done_seen), 32'd1);

    // same load with in_valid toggling
    wr_seen = 0; done_seen = 0;
    step(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 2 * NUM_TAPS; i++)
      step(0, 0, 0, (i % 2) == 0, (i % 2) == 0 ? 16'(i / 2 + 1) : 16'($urandom));
    idle_step();
    check("gapped_writes", 32'(wr_seen), 32'(NUM_TAPS));
    check("gapped_done_count", 32'(done_seen), 32'd1);

    // timeout after 5 coefficients, stay in ERR, then restart
    step(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 16'($urandom));
    for (int i = 0; i < TIMEOUT; i++) idle_step();
    check("timeout_error", 32'(error), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1'($urandom_range(0, 1)), 16'($urandom));
    wr_seen = 0; done_seen = 0;
    step(0, 1, 0, 0, 16'h0);
    for (int k = 0; k < NUM_TAPS; k++) step(0, 0, 0, 1, 16'($urandom));
    idle_step();
    check("restart_writes", 32'(wr_seen), 32'(NUM_TAPS));

    // abort on the 10th handshake
    wr_seen = 0; done_seen = 0;
    step(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 16'($urandom));
    step(0, 0, 1, 1, 16'hABCD);
    for (int i = 0; i < 3; i++) idle_step();
    check("abort_writes", 32'(wr_seen), 32'd10);
    check("abort_done_count", 32'(done_seen), 32'd0);

    // reset during a handshake drops the pending write
    step(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'($urandom));
    step(1, 0, 0, 1, 16'h5555);
    idle_step();

    // checksum load: 41 x 0x1000
    step(0, 1, 0, 0, 16'h0);
    for (int k = 0; k < NUM_TAPS; k++) step(0, 0, 0, 1, 16'h1000);
`ifdef COEFF_CHECKSUM_EN
    check("checksum_0x9000", 32'(checksum), 32'h9000);
`endif
    idle_step();

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, 16'($urandom));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 16'h0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
